// File: rtl/cluster_demux_pkg.sv
// Shared widths, slot types and small helpers for the cluster stream demultiplexer.
package cluster_demux_pkg;

  localparam int unsigned MXCLUSTERS        = 8;
  localparam int unsigned MXADRB            = 11;
  localparam int unsigned MXCNTB            = 3;
  localparam int unsigned NPHASES           = 8;
  localparam int unsigned ADR_INVALID_LIMIT = 1536;

  localparam int unsigned PHASEB   = $clog2(NPHASES);
  localparam int unsigned NCLUSTB  = $clog2(MXCLUSTERS + 1);
  localparam int unsigned ADR_BUSW = MXCLUSTERS * MXADRB;
  localparam int unsigned CNT_BUSW = MXCLUSTERS * MXCNTB;

  typedef logic [PHASEB-1:0]     phase_t;
  typedef logic [MXCLUSTERS-1:0] vld_t;
  typedef logic [NCLUSTB-1:0]    nclust_t;
  typedef logic [ADR_BUSW-1:0]   adr_bus_t;
  typedef logic [CNT_BUSW-1:0]   cnt_bus_t;

  typedef struct packed {
    logic [MXADRB-1:0] adr;
    logic [MXCNTB-1:0] cnt;
  } cluster_t;

  function automatic cluster_t get_slot(input adr_bus_t adr, input cnt_bus_t cnt,
                                        input int unsigned k);
    cluster_t s;
    s.adr = adr[k*MXADRB +: MXADRB];
    s.cnt = cnt[k*MXCNTB +: MXCNTB];
    return s;
  endfunction

  function automatic nclust_t popcount(input vld_t v);
    nclust_t n;
    n = '0;
    for (int unsigned i = 0; i < MXCLUSTERS; i++)
      n = n + nclust_t'(v[i]);
    return n;
  endfunction

  // True when the valid slots form a contiguous run starting at slot 0 (2^n-1).
  function automatic logic is_prefix_mask(input vld_t v);
    return (v & (v + vld_t'(1))) == '0;
  endfunction

endpackage

// File: rtl/cluster_demux_if.sv
// Muxed slot input bus plus de-interleaved frame outputs of the cluster demultiplexer.
interface cluster_demux_if;
  import cluster_demux_pkg::*;

  logic     resync;
  adr_bus_t adr_in;
  cnt_bus_t cnt_in;

  adr_bus_t even_adr;
  cnt_bus_t even_cnt;
  adr_bus_t odd_adr;
  cnt_bus_t odd_cnt;
  vld_t     even_vld;
  vld_t     odd_vld;
  nclust_t  even_nclust;
  nclust_t  odd_nclust;
  logic     frame_valid;
  logic     overflow;
  logic     order_err;

  modport master (
    output resync, adr_in, cnt_in,
    input  even_adr, even_cnt, odd_adr, odd_cnt, even_vld, odd_vld,
           even_nclust, odd_nclust, frame_valid, overflow, order_err
  );

  modport slave (
    input  resync, adr_in, cnt_in,
    output even_adr, even_cnt, odd_adr, odd_cnt, even_vld, odd_vld,
           even_nclust, odd_nclust, frame_valid, overflow, order_err
  );

endinterface

// File: rtl/cluster_bank_capture.sv
// One parity bank: captures all 8 slots on cap_i and registers valid mask, count and integrity bits.
module cluster_bank_capture
  import cluster_demux_pkg::*;
#(
  parameter int unsigned ADR_LIMIT = ADR_INVALID_LIMIT
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     cap_i,
  input  adr_bus_t adr_i,
  input  cnt_bus_t cnt_i,
  output adr_bus_t adr_o,
  output cnt_bus_t cnt_o,
  output vld_t     vld_o,
  output nclust_t  nclust_o,
  output logic     full_o,
  output logic     order_err_o
);

  adr_bus_t adr_q;
  cnt_bus_t cnt_q;
  vld_t     vld_q, vld_d;
  nclust_t  nclust_q;
  logic     full_q;
  logic     order_err_q;
  cluster_t slot;

  always_comb begin
    vld_d = '0;
    slot  = '0;
    for (int unsigned k = 0; k < MXCLUSTERS; k++) begin
      slot     = get_slot(adr_i, cnt_i, k);
      vld_d[k] = 32'(slot.adr) < ADR_LIMIT;
    end
  end

  // Invalid slots keep their raw adr/cnt; only the valid mask marks them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_q       <= '0;
      cnt_q       <= '0;
      vld_q       <= '0;
      nclust_q    <= '0;
      full_q      <= 1'b0;
      order_err_q <= 1'b0;
    end else if (cap_i) begin
      adr_q       <= adr_i;
      cnt_q       <= cnt_i;
      vld_q       <= vld_d;
      nclust_q    <= popcount(vld_d);
      full_q      <= &vld_d;
      order_err_q <= !is_prefix_mask(vld_d);
    end
  end

  assign adr_o       = adr_q;
  assign cnt_o       = cnt_q;
  assign vld_o       = vld_q;
  assign nclust_o    = nclust_q;
  assign full_o      = full_q;
  assign order_err_o = order_err_q;

endmodule

// File: rtl/cluster_demux.sv
// De-interleaves the 160 MHz muxed cluster stream into even/odd BX banks, published once per frame.
module cluster_demux
  import cluster_demux_pkg::*;
#(
  parameter phase_t      CAP_EVEN  = 3'd3,
  parameter phase_t      CAP_ODD   = 3'd7,
  parameter int unsigned ADR_LIMIT = ADR_INVALID_LIMIT
) (
  input logic             clock4x,
  input logic             reset,
  cluster_demux_if.slave  bus
);

  phase_t phase_q, phase_d;
  logic   cap_even, cap_odd;

  adr_bus_t hold_adr, odd_adr;
  cnt_bus_t hold_cnt, odd_cnt;
  vld_t     hold_vld, odd_vld;
  nclust_t  hold_nclust, odd_nclust;
  logic     hold_full, odd_full;
  logic     hold_order, odd_order;
  logic     hold_full_q;

  adr_bus_t ev_adr_q;
  cnt_bus_t ev_cnt_q;
  vld_t     ev_vld_q;
  nclust_t  ev_nclust_q;
  logic     ev_full_q, ev_order_q;
  logic     pub_q;

  adr_bus_t even_adr_q, odd_adr_q;
  cnt_bus_t even_cnt_q, odd_cnt_q;
  vld_t     even_vld_q, odd_vld_q;
  nclust_t  even_nclust_q, odd_nclust_q;
  logic     frame_valid_q, overflow_q, order_err_q;

  assign cap_even = (phase_q == CAP_EVEN);
  assign cap_odd  = (phase_q == CAP_ODD);

  // Capture decisions use the current phase, so a resync on a capture edge still captures.
  always_comb begin
    phase_d = phase_q + phase_t'(1);
    if (bus.resync)
      phase_d = '0;
  end

  cluster_bank_capture #(.ADR_LIMIT(ADR_LIMIT)) u_hold_bank (
    .clk_i       (clock4x),
    .rst_i       (reset),
    .cap_i       (cap_even),
    .adr_i       (bus.adr_in),
    .cnt_i       (bus.cnt_in),
    .adr_o       (hold_adr),
    .cnt_o       (hold_cnt),
    .vld_o       (hold_vld),
    .nclust_o    (hold_nclust),
    .full_o      (hold_full),
    .order_err_o (hold_order)
  );

  cluster_bank_capture #(.ADR_LIMIT(ADR_LIMIT)) u_odd_bank (
    .clk_i       (clock4x),
    .rst_i       (reset),
    .cap_i       (cap_odd),
    .adr_i       (bus.adr_in),
    .cnt_i       (bus.cnt_in),
    .adr_o       (odd_adr),
    .cnt_o       (odd_cnt),
    .vld_o       (odd_vld),
    .nclust_o    (odd_nclust),
    .full_o      (odd_full),
    .order_err_o (odd_order)
  );

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      phase_q       <= '0;
      hold_full_q   <= 1'b0;
      ev_adr_q      <= '0;
      ev_cnt_q      <= '0;
      ev_vld_q      <= '0;
      ev_nclust_q   <= '0;
      ev_full_q     <= 1'b0;
      ev_order_q    <= 1'b0;
      pub_q         <= 1'b0;
      even_adr_q    <= '0;
      even_cnt_q    <= '0;
      odd_adr_q     <= '0;
      odd_cnt_q     <= '0;
      even_vld_q    <= '0;
      odd_vld_q     <= '0;
      even_nclust_q <= '0;
      odd_nclust_q  <= '0;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      order_err_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      hold_full_q <= hold_full_q | cap_even;
      pub_q       <= cap_odd;

      // Until a real even capture has happened since reset, the even stage reports empty.
      if (cap_odd) begin
        ev_adr_q    <= hold_adr;
        ev_cnt_q    <= hold_cnt;
        ev_vld_q    <= hold_full_q ? hold_vld : '0;
        ev_nclust_q <= hold_full_q ? hold_nclust : '0;
        ev_full_q   <= hold_full_q & hold_full;
        ev_order_q  <= hold_full_q & hold_order;
      end

      frame_valid_q <= pub_q;
      if (pub_q) begin
        even_adr_q    <= ev_adr_q;
        even_cnt_q    <= ev_cnt_q;
        odd_adr_q     <= odd_adr;
        odd_cnt_q     <= odd_cnt;
        even_vld_q    <= ev_vld_q;
        odd_vld_q     <= odd_vld;
        even_nclust_q <= ev_nclust_q;
        odd_nclust_q  <= odd_nclust;
        overflow_q    <= overflow_q | ev_full_q | odd_full;
        order_err_q   <= order_err_q | ev_order_q | odd_order;
      end
    end
  end

  assign bus.even_adr    = even_adr_q;
  assign bus.even_cnt    = even_cnt_q;
  assign bus.odd_adr     = odd_adr_q;
  assign bus.odd_cnt     = odd_cnt_q;
  assign bus.even_vld    = even_vld_q;
  assign bus.odd_vld     = odd_vld_q;
  assign bus.even_nclust = even_nclust_q;
  assign bus.odd_nclust  = odd_nclust_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.order_err   = order_err_q;

endmodule

// File: tb/tb_cluster_demux.sv
// Self-checking bench for cluster_demux against an event-level model of the frame timing and flags.
module tb_cluster_demux;
  import cluster_demux_pkg::*;

  localparam int CAP_EVEN = 3;
  localparam int CAP_ODD  = 7;

  typedef struct packed {
    logic [87:0] ea;
    logic [23:0] ec;
    logic [87:0] oa;
    logic [23:0] oc;
    logic [7:0]  ev;
    logic [7:0]  ov;
    logic [3:0]  en;
    logic [3:0]  on;
  } frame_t;

  typedef logic [250:0] vec_t;

  logic clock4x = 1'b0;
  logic reset   = 1'b1;
  cluster_demux_if bus();

  cluster_demux #(.CAP_EVEN(3'd3), .CAP_ODD(3'd7), .ADR_LIMIT(1536)) dut (
    .clock4x (clock4x),
    .reset   (reset),
    .bus     (bus)
  );

  always #3 clock4x = ~clock4x;

  int errors = 0;
  int checks = 0;

  int          m_phase;
  bit          m_have_even, m_pend, m_fv, m_ovf, m_ord;
  logic [87:0] m_hold_adr;
  logic [23:0] m_hold_cnt;
  frame_t      m_frame, m_pend_frame;

  function automatic logic [7:0] vmask(input logic [87:0] adr);
    logic [7:0] v;
    logic [10:0] a;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      a    = adr[k*11 +: 11];
      v[k] = (int'(a) < 1536);
    end
    return v;
  endfunction

  function automatic logic [3:0] ones(input logic [7:0] v);
    int n = 0;
    for (int k = 0; k < 8; k++) if (v[k]) n++;
    return 4'(n);
  endfunction

  function automatic bit has_gap(input logic [7:0] v);
    bit seen_invalid = 0;
    for (int k = 0; k < 8; k++) begin
      if (!v[k]) seen_invalid = 1;
      else if (seen_invalid) return 1;
    end
    return 0;
  endfunction

  function automatic vec_t exp_vec();
    return {m_frame, m_fv, m_ovf, m_ord};
  endfunction

  function automatic vec_t dut_vec();
    return {bus.even_adr, bus.even_cnt, bus.odd_adr, bus.odd_cnt, bus.even_vld, bus.odd_vld,
            bus.even_nclust, bus.odd_nclust, bus.frame_valid, bus.overflow, bus.order_err};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_have_even = 0; m_pend = 0; m_fv = 0; m_ovf = 0; m_ord = 0;
    m_hold_adr = '0; m_hold_cnt = '0; m_frame = '0; m_pend_frame = '0;
  endtask

  // A frame is published on the edge after the odd capture; flags accumulate at publish.
  task automatic model_edge();
    m_fv = 0;
    if (m_pend) begin
      m_frame = m_pend_frame;
      m_fv    = 1;
      m_pend  = 0;
      if (m_frame.ev == 8'hFF || m_frame.ov == 8'hFF) m_ovf = 1;
      if (has_gap(m_frame.ev) || has_gap(m_frame.ov)) m_ord = 1;
    end
    if (m_phase == CAP_EVEN) begin
      m_hold_adr  = bus.adr_in;
      m_hold_cnt  = bus.cnt_in;
      m_have_even = 1;
    end
    if (m_phase == CAP_ODD) begin
      m_pend_frame.ea = m_hold_adr;
      m_pend_frame.ec = m_hold_cnt;
      m_pend_frame.ev = m_have_even ? vmask(m_hold_adr) : 8'h00;
      m_pend_frame.en = ones(m_pend_frame.ev);
      m_pend_frame.oa = bus.adr_in;
      m_pend_frame.oc = bus.cnt_in;
      m_pend_frame.ov = vmask(bus.adr_in);
      m_pend_frame.on = ones(m_pend_frame.ov);
      m_pend = 1;
    end
    m_phase = bus.resync ? 0 : (m_phase + 1) % 8;
  endtask

  task automatic tick();
    @(posedge clock4x);
    model_edge();
    #1;
  endtask

  task automatic set_slot(input int k, input int adr, input int cnt);
    bus.adr_in[k*11 +: 11] = 11'(adr);
    bus.cnt_in[k*3 +: 3]   = 3'(cnt);
  endtask

  task automatic set_all_invalid();
    for (int k = 0; k < 8; k++) set_slot(k, 2047, $urandom_range(0, 7));
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (m_phase != p && n < 16) begin
      tick();
      n++;
    end
    checks++;
    if (m_phase != p) begin
      errors++;
      $display("FAIL wait_phase: phase %0d not reached, at %0d", p, m_phase);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock4x);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.resync = 1'b0;
    set_all_invalid();
    do_reset();
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", dut_vec());
    end
  endtask

  task automatic test_first_frame();
    bit want;
    for (int n = 1; n <= 26; n++) begin
      tick();
      want = (n == 9 || n == 17 || n == 25);
      checks++;
      if (bus.frame_valid !== want) begin
        errors++;
        $display("FAIL first_frame_timing n=%0d: got %b want %b", n, bus.frame_valid, want);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL first_frame_vec n=%0d: got %h want %h", n, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_even_partial();
    wait_phase(CAP_EVEN);
    set_all_invalid();
    set_slot(0, 5, 1); set_slot(1, 100, 2); set_slot(2, 1535, 7);
    tick();
    set_all_invalid();
    wait_phase(CAP_ODD);
    tick();
    tick();
    checks++;
    if ({bus.frame_valid, bus.even_vld, bus.even_nclust, bus.odd_vld} !== {1'b1, 8'h07, 4'd3, 8'h00}) begin
      errors++;
      $display("FAIL even_partial: got fv=%b ev=%h en=%0d ov=%h want 1 07 3 00",
               bus.frame_valid, bus.even_vld, bus.even_nclust, bus.odd_vld);
    end
    checks++;
    if ({bus.even_adr[32:0], bus.even_cnt[8:0]} !== {11'd1535, 11'd100, 11'd5, 3'd7, 3'd2, 3'd1}) begin
      errors++;
      $display("FAIL even_partial_data: got %h %h", bus.even_adr[32:0], bus.even_cnt[8:0]);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL even_partial_vec: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_order();
    wait_phase(CAP_EVEN);
    set_all_invalid();
    set_slot(1, 10, 3); set_slot(2, 1536, 4);
    tick();
    set_all_invalid();
    wait_phase(CAP_ODD);
    tick();
    tick();
    checks++;
    if ({bus.even_vld, bus.order_err, bus.overflow} !== {8'h02, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL order_err: got ev=%h oe=%b ovf=%b want 02 1 0",
               bus.even_vld, bus.order_err, bus.overflow);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL order_vec: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_overflow();
    wait_phase(CAP_ODD);
    for (int k = 0; k < 8; k++) set_slot(k, k, k);
    tick();
    set_all_invalid();
    tick();
    checks++;
    if ({bus.frame_valid, bus.odd_vld, bus.odd_nclust, bus.overflow} !== {1'b1, 8'hFF, 4'd8, 1'b1}) begin
      errors++;
      $display("FAIL overflow: got fv=%b ov=%h on=%0d ovf=%b want 1 ff 8 1",
               bus.frame_valid, bus.odd_vld, bus.odd_nclust, bus.overflow);
    end
    repeat (16) tick();
    checks++;
    if ({bus.odd_vld, bus.overflow} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL overflow_sticky: got ov=%h ovf=%b want 00 1", bus.odd_vld, bus.overflow);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL overflow_vec: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_resync();
    bit want;
    wait_phase(5);
    bus.resync = 1'b1;
    tick();
    bus.resync = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      want = (n == 9 || n == 17);
      checks++;
      if (bus.frame_valid !== want) begin
        errors++;
        $display("FAIL resync_timing n=%0d: got %b want %b", n, bus.frame_valid, want);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL resync_vec n=%0d: got %h want %h", n, dut_vec(), exp_vec());
      end
    end
    // resync coinciding with the odd capture edge must not suppress the capture
    wait_phase(CAP_ODD);
    bus.resync = 1'b1;
    set_all_invalid();
    set_slot(0, 42, 5);
    tick();
    bus.resync = 1'b0;
    set_all_invalid();
    tick();
    checks++;
    if ({bus.frame_valid, bus.odd_vld, bus.odd_adr[10:0]} !== {1'b1, 8'h01, 11'd42}) begin
      errors++;
      $display("FAIL resync_on_capture: got fv=%b ov=%h a0=%0d want 1 01 42",
               bus.frame_valid, bus.odd_vld, bus.odd_adr[10:0]);
    end
  endtask

  task automatic test_reset_midframe();
    bit seen = 0;
    wait_phase(CAP_EVEN);
    for (int k = 0; k < 8; k++) set_slot(k, k * 3, 6);
    tick();
    set_all_invalid();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_midframe_clear: got %h want 0", dut_vec());
    end
    model_reset();
    repeat (2) @(posedge clock4x);
    #1 reset = 1'b0;
    for (int n = 1; n <= 12 && !seen; n++) begin
      tick();
      if (bus.frame_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (n != 9) begin
          errors++;
          $display("FAIL reset_first_frame_time: got %0d want 9", n);
        end
        checks++;
        if ({bus.even_adr, bus.even_vld, bus.overflow, bus.order_err} !== {{88{1'b1}}, 8'h00, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL reset_stale_even: got %h ev=%h ovf=%b oe=%b",
                   bus.even_adr, bus.even_vld, bus.overflow, bus.order_err);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_first_frame: got none want frame_valid within 12 clocks");
    end
  endtask

  task automatic test_random();
    int mode, nv;
    for (int n = 0; n < 96; n++) begin
      mode = $urandom_range(0, 3);
      nv   = $urandom_range(0, 8);
      for (int k = 0; k < 8; k++) begin
        if (mode == 0) set_slot(k, $urandom_range(0, 2047), $urandom_range(0, 7));
        else if (k < nv) set_slot(k, $urandom_range(0, 1535), $urandom_range(0, 7));
        else set_slot(k, $urandom_range(1536, 2047), $urandom_range(0, 7));
      end
      bus.resync = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_vec n=%0d: got %h want %h", n, dut_vec(), exp_vec());
      end
    end
    bus.resync = 1'b0;
  endtask

  initial begin
    bus.resync = 1'b0;
    bus.adr_in = '1;
    bus.cnt_in = '0;
    test_reset();
    test_first_frame();
    test_even_partial();
    test_order();
    test_overflow();
    test_resync();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
